instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the CPU core; drives the core's 20-bit instruction input.
- Holds a writable program memory and a program counter (PC), and runs a small IDLE/RUN/HALT state machine.
- Issues one registered instruction per cycle; supports stall, redirect from the control unit, and self-halt on a HALT opcode.
- Issues NOP whenever no valid instruction is available, because the core has no valid input.

---
 rtl/instr_fetch_if.sv | 54 +++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of program-load, fetch-control and issued-instruction signals that sit
// between the fetch stage and its surroundings (loader, control unit, core).
interface instr_fetch_if #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 5
);

  logic                      load_en;
  logic [PROG_ADDR_BITS-1:0] load_addr;
  logic [INSTR_WIDTH-1:0]    load_data;
  logic                      start;
  logic                      stall;
  logic                      branch_en;
  logic [PROG_ADDR_BITS-1:0] branch_target;

  logic [INSTR_WIDTH-1:0]    instruction;
  logic                      instr_valid;
  logic [PROG_ADDR_BITS-1:0] pc;
  logic                      halted;
  logic [7:0]                fetch_count;

  // The side that loads the program, steers fetch and consumes instructions
  modport master (
    output load_en,
    output load_addr,
    output load_data,
    output start,
    output stall,
    output branch_en,
    output branch_target,
    input  instruction,
    input  instr_valid,
    input  pc,
    input  halted,
    input  fetch_count
  );

  // The fetch stage itself
  modport slave (
    input  load_en,
    input  load_addr,
    input  load_data,
    input  start,
    input  stall,
    input  branch_en,
    input  branch_target,
    output instruction,
    output instr_valid,
    output pc,
    output halted,
    output fetch_count
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: writable program memory, PC and IDLE/RUN/HALT control,
// issuing one registered instruction per cycle (NOP whenever nothing valid).
module instr_fetch #(
  parameter int                     INSTR_WIDTH    = 20,
  parameter int                     PROG_ADDR_BITS = 5,
  parameter logic [3:0]             HALT_OPCODE    = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = '0
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.slave bus
);

  localparam int MEM_DEPTH = 2 ** PROG_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic                      halted_q, halted_d;
  logic [7:0]                count_q, count_d;
  logic                      mem_we;

  logic [INSTR_WIDTH-1:0]    mem [MEM_DEPTH];
  logic [INSTR_WIDTH-1:0]    fetch_word;
  logic [3:0]                fetch_opcode;

  assign fetch_word   = mem[pc_q];
  assign fetch_opcode = fetch_word[INSTR_WIDTH-1 -: 4];

  // Program memory is deliberately outside the reset domain so a reset keeps
  // the loaded program; writes are only accepted while idle and out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        mem_we   = bus.load_en && rst;
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          count_d = '0;
        end
      end

      RUN: begin
        // Stall beats branch beats halt detection beats a normal issue
        if (bus.stall) begin
          state_d = RUN;
        end else if (bus.branch_en) begin
          pc_d    = bus.branch_target;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (fetch_opcode == HALT_OPCODE) begin
          state_d  = HALT;
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          pc_d    = pc_q + PROG_ADDR_BITS'(1);
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
      end

      HALT: begin
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        halted_d = 1'b1;
        if (bus.start) begin
          state_d  = RUN;
          pc_d     = '0;
          count_d  = '0;
          halted_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-scenario tasks with a scoreboard queue
// of expected issued words, sampled 1 time unit after each rising edge.
module tb_instr_fetch;

  localparam int IW = 20;
  localparam int AW = 5;
  localparam logic [IW-1:0] NOP = 20'h00000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_fetch_if #(.INSTR_WIDTH(IW), .PROG_ADDR_BITS(AW)) bus ();

  instr_fetch #(
    .INSTR_WIDTH(IW),
    .PROG_ADDR_BITS(AW),
    .HALT_OPCODE(4'hF),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] exp_q [$];
  logic [IW-1:0] model_mem [32];
  logic [IW-1:0] exp_word;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load_en       = 1'b0;
    bus.load_addr     = '0;
    bus.load_data     = '0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = '0;
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [IW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.instruction !== NOP) begin n_fail++; $display("[TB] FAIL reset_instr: got %h want %h", bus.instruction, NOP); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.pc !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_pc: got %0d want 0", bus.pc); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b want 0", bus.halted); end
    n_checks++; if (bus.fetch_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", bus.fetch_count); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_run();
    load_word(5'd0, 20'h10001);
    load_word(5'd1, 20'h20002);
    load_word(5'd2, 20'h30003);
    load_word(5'd3, 20'hF0000);
    exp_q.push_back(20'h10001);
    exp_q.push_back(20'h20002);
    exp_q.push_back(20'h30003);
    pulse_start();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL run_entry_valid: got %b want 0", bus.instr_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_word = exp_q.pop_front();
      n_checks++; if (bus.instruction !== exp_word || bus.instr_valid !== 1'b1) begin
        n_fail++; $display("[TB] FAIL run_word%0d: got %h/%b want %h/1", i, bus.instruction, bus.instr_valid, exp_word);
      end
    end
    tick();
    n_checks++; if (bus.instruction !== NOP || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_output: got %h/%b want %h/0", bus.instruction, bus.instr_valid, NOP); end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_flag: got %b want 1", bus.halted); end
    n_checks++; if (bus.pc !== 5'd3) begin n_fail++; $display("[TB] FAIL halt_pc: got %0d want 3", bus.pc); end
    n_checks++; if (bus.fetch_count !== 8'd3) begin n_fail++; $display("[TB] FAIL halt_count: got %0d want 3", bus.fetch_count); end
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.pc !== 5'd3) begin n_fail++; $display("[TB] FAIL halt_hold: got halted=%b pc=%0d want halted=1 pc=3", bus.halted, bus.pc); end
  endtask

  task automatic test_stall();
    pulse_start();
    n_checks++; if (bus.halted !== 1'b0 || bus.pc !== 5'd0) begin n_fail++; $display("[TB] FAIL restart_from_halt: got halted=%b pc=%0d want halted=0 pc=0", bus.halted, bus.pc); end
    tick();
    tick();
    n_checks++; if (bus.instruction !== 20'h20002) begin n_fail++; $display("[TB] FAIL stall_pre: got %h want 20002", bus.instruction); end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.instruction !== 20'h20002 || bus.instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_instr%0d: got %h/%b want 20002/1", i, bus.instruction, bus.instr_valid); end
      n_checks++; if (bus.pc !== 5'd2) begin n_fail++; $display("[TB] FAIL stall_pc%0d: got %0d want 2", i, bus.pc); end
      n_checks++; if (bus.fetch_count !== 8'd2) begin n_fail++; $display("[TB] FAIL stall_count%0d: got %0d want 2", i, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.instruction !== 20'h30003) begin n_fail++; $display("[TB] FAIL stall_release: got %h want 30003", bus.instruction); end
    tick();
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_end_halt: got %b want 1", bus.halted); end
  endtask

  task automatic test_branch();
    do_reset();
    load_word(5'd5, 20'h55555);
    load_word(5'd6, 20'hF0000);
    pulse_start();
    tick();
    n_checks++; if (bus.instruction !== 20'h10001 || bus.pc !== 5'd1) begin n_fail++; $display("[TB] FAIL branch_pre: got %h pc=%0d want 10001 pc=1", bus.instruction, bus.pc); end
    bus.stall = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_target = 5'd5;
    tick();
    n_checks++; if (bus.pc !== 5'd1 || bus.instruction !== 20'h10001) begin n_fail++; $display("[TB] FAIL stall_over_branch: got pc=%0d %h want pc=1 10001", bus.pc, bus.instruction); end
    bus.stall = 1'b0;
    tick();
    bus.branch_en = 1'b0;
    n_checks++; if (bus.instruction !== NOP || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL branch_squash: got %h/%b want %h/0", bus.instruction, bus.instr_valid, NOP); end
    n_checks++; if (bus.pc !== 5'd5) begin n_fail++; $display("[TB] FAIL branch_pc: got %0d want 5", bus.pc); end
    n_checks++; if (bus.fetch_count !== 8'd1) begin n_fail++; $display("[TB] FAIL branch_count: got %0d want 1", bus.fetch_count); end
    exp_q.push_back(model_mem[5]);
    tick();
    exp_word = exp_q.pop_front();
    n_checks++; if (bus.instruction !== exp_word || bus.instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL branch_target_word: got %h/%b want %h/1", bus.instruction, bus.instr_valid, exp_word); end
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.pc !== 5'd6) begin n_fail++; $display("[TB] FAIL branch_halt: got halted=%b pc=%0d want 1 pc=6", bus.halted, bus.pc); end
  endtask

  task automatic test_ignored_inputs();
    bus.load_en = 1'b1;
    bus.load_addr = 5'd0;
    bus.load_data = 20'hAAAAA;
    tick();
    clear_inputs();
    pulse_start();
    tick();
    n_checks++; if (bus.instruction !== 20'h10001) begin n_fail++; $display("[TB] FAIL halt_load_ignored: got %h want 10001", bus.instruction); end
    bus.load_en = 1'b1;
    bus.load_addr = 5'd2;
    bus.load_data = 20'h77777;
    bus.start = 1'b1;
    tick();
    clear_inputs();
    n_checks++; if (bus.instruction !== 20'h20002 || bus.pc !== 5'd2) begin n_fail++; $display("[TB] FAIL run_start_ignored: got %h pc=%0d want 20002 pc=2", bus.instruction, bus.pc); end
    tick();
    n_checks++; if (bus.instruction !== 20'h30003) begin n_fail++; $display("[TB] FAIL run_load_ignored: got %h want 30003", bus.instruction); end
    tick();
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("[TB] FAIL ignored_end_halt: got %b want 1", bus.halted); end
  endtask

  task automatic test_reset_mid_run();
    int budget;
    pulse_start();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (bus.instruction !== NOP || bus.instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out: got %h/%b want %h/0", bus.instruction, bus.instr_valid, NOP); end
    n_checks++; if (bus.pc !== 5'd0 || bus.fetch_count !== 8'd0 || bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_state: got pc=%0d cnt=%0d h=%b want 0 0 0", bus.pc, bus.fetch_count, bus.halted); end
    tick();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_idle: got valid=%b pc=%0d want 0 0", bus.instr_valid, bus.pc); end
    for (int a = 0; a < 3; a++) exp_q.push_back(model_mem[a]);
    pulse_start();
    budget = 10;
    while (!bus.halted && budget > 0) begin
      tick();
      budget--;
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("[TB] FAIL replay_extra: got %h want nothing", bus.instruction);
        end else begin
          exp_word = exp_q.pop_front();
          n_checks++; if (bus.instruction !== exp_word) begin n_fail++; $display("[TB] FAIL replay_word: got %h want %h", bus.instruction, exp_word); end
        end
      end
    end
    n_checks++; if (bus.halted !== 1'b1 || exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL replay_done: got halted=%b left=%0d want 1 0", bus.halted, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_load_start_same_cycle();
    do_reset();
    bus.load_en = 1'b1;
    bus.load_addr = 5'd0;
    bus.load_data = 20'h12345;
    bus.start = 1'b1;
    tick();
    clear_inputs();
    model_mem[0] = 20'h12345;
    tick();
    n_checks++; if (bus.instruction !== 20'h12345 || bus.instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL load_start_word: got %h/%b want 12345/1", bus.instruction, bus.instr_valid); end
  endtask

  task automatic test_wrap_saturate();
    logic [AW-1:0] exp_pc;
    logic [7:0] exp_cnt;
    int wraps;
    do_reset();
    for (int i = 0; i < 32; i++) load_word(AW'(i), 20'h10000 + IW'(i) * 20'h00111);
    pulse_start();
    exp_pc = '0;
    exp_cnt = '0;
    wraps = 0;
    for (int c = 0; c < 300; c++) begin
      exp_q.push_back(model_mem[exp_pc]);
      exp_pc = exp_pc + 5'd1;
      if (exp_pc == 5'd0) wraps++;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      tick();
      exp_word = exp_q.pop_front();
      n_checks++; if (bus.instruction !== exp_word || bus.instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_word c=%0d: got %h/%b want %h/1", c, bus.instruction, bus.instr_valid, exp_word); end
      n_checks++; if (bus.pc !== exp_pc) begin n_fail++; $display("[TB] FAIL wrap_pc c=%0d: got %0d want %0d", c, bus.pc, exp_pc); end
      n_checks++; if (bus.fetch_count !== exp_cnt) begin n_fail++; $display("[TB] FAIL wrap_count c=%0d: got %0d want %0d", c, bus.fetch_count, exp_cnt); end
    end
    n_checks++; if (bus.fetch_count !== 8'd255) begin n_fail++; $display("[TB] FAIL saturate_final: got %0d want 255", bus.fetch_count); end
    n_checks++; if (wraps != 9) begin n_fail++; $display("[TB] FAIL wrap_events: got %0d want 9", wraps); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_run();
    test_stall();
    test_branch();
    test_ignored_inputs();
    test_reset_mid_run();
    test_load_start_same_cycle();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
